pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer.

---
 rtl/pipe_stage_skid.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Pipeline stage register with a valid/ready handshake and a two-entry
//   skid buffer (main + skid). Each entry carries a data payload and a
//   control field. in_ready and out_valid come straight from flops, so no
//   combinational path runs from out_ready to in_ready through the stage.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream entry valid
//   in_ready   stage can accept this cycle (registered)
//   in_data    upstream payload
//   in_ctrl    upstream control
//   out_valid  main entry valid
//   out_ready  downstream accepts main entry
//   out_data   main entry payload
//   out_ctrl   main entry control, CTRL_RST whenever out_valid is low
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held; in_ready=1, out_valid=0
// ST_FULL  | main entry held; in_ready=1, out_valid=1
// ST_SKID  | main and skid entries held; in_ready=0, out_valid=1

module pipe_stage_skid #(
    parameter int                 DATA_W      = 64,
    parameter int                 CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]  CTRL_RST    = '0,
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_t;

    state_t                  state;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [DATA_W-1:0]       main_data;
    logic [CTRL_W-1:0]       main_ctrl;
    logic [DATA_W-1:0]       skid_data;
    logic [CTRL_W-1:0]       skid_ctrl;
    logic [STALL_CNT_W-1:0]  stall_cnt_r;

    logic acc_in;
    logic acc_out;

    assign acc_in  = in_valid & in_ready_r;
    assign acc_out = out_valid_r & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            main_data   <= '0;
            main_ctrl   <= CTRL_RST;
            skid_data   <= '0;
            skid_ctrl   <= CTRL_RST;
            stall_cnt_r <= '0;
        end else begin
            // Counts regardless of flush; only reset clears it.
            if (out_valid_r && !out_ready && (stall_cnt_r != '1))
                stall_cnt_r <= stall_cnt_r + 1'b1;

            if (flush) begin
                // Payload registers keep their contents; out_ctrl is masked.
                state       <= ST_EMPTY;
                in_ready_r  <= 1'b1;
                out_valid_r <= 1'b0;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        in_ready_r <= 1'b1;
                        if (acc_in) begin
                            state       <= ST_FULL;
                            out_valid_r <= 1'b1;
                            main_data   <= in_data;
                            main_ctrl   <= in_ctrl;
                        end else begin
                            out_valid_r <= 1'b0;
                        end
                    end
                    ST_FULL: begin
                        if (acc_in && acc_out) begin
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b1;
                            main_data   <= in_data;
                            main_ctrl   <= in_ctrl;
                        end else if (acc_in) begin
                            // Downstream stalled: park the new beat behind main.
                            state       <= ST_SKID;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            skid_data   <= in_data;
                            skid_ctrl   <= in_ctrl;
                        end else if (acc_out) begin
                            state       <= ST_EMPTY;
                            out_valid_r <= 1'b0;
                            in_ready_r  <= 1'b1;
                        end else begin
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b1;
                        end
                    end
                    ST_SKID: begin
                        out_valid_r <= 1'b1;
                        if (acc_out) begin
                            state      <= ST_FULL;
                            in_ready_r <= 1'b1;
                            main_data  <= skid_data;
                            main_ctrl  <= skid_ctrl;
                        end else begin
                            in_ready_r <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid_r ? main_ctrl : CTRL_RST;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int             DW = 16;
    localparam int             CW = 8;
    localparam int             SW = 4;
    localparam logic [CW-1:0]  CR = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [SW-1:0] stall_cnt;

    pipe_stage_skid #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CR), .STALL_CNT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    logic [DW+CW-1:0] q[$];
    int unsigned      scnt;
    logic             m_valid, m_ready;

    initial begin
        // 1: reset held 3 cycles with in_valid asserted
        rst = 1'b0;
        drive(1'b1, 16'h1234, 8'h11);
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, CR);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_data", out_data, 0);

        // 2: streaming, one beat per cycle, 1-cycle latency
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(i), CW'(i));
            step();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, i);
            chk("stream_ctrl", out_ctrl, i);
            chk("stream_ready", in_ready, 1);
        end
        drive(1'b0, '0, '0);
        step();
        chk("stream_drained", out_valid, 0);
        chk("stream_stall", stall_cnt, 0);

        // 3: skid fill and drain
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 8'h01);
        step();
        chk("skid_a_valid", out_valid, 1);
        chk("skid_a_data", out_data, 16'h00AA);
        chk("skid_a_ready", in_ready, 1);
        drive(1'b1, 16'h00BB, 8'h02);
        step();
        chk("skid_full_ready", in_ready, 0);
        chk("skid_main_data", out_data, 16'h00AA);
        chk("skid_main_ctrl", out_ctrl, 8'h01);
        chk("skid_stall", stall_cnt, 1);
        drive(1'b1, 16'h00CC, 8'h03);
        out_ready = 1'b1;
        step();
        chk("skid_b_data", out_data, 16'h00BB);
        chk("skid_b_ctrl", out_ctrl, 8'h02);
        chk("skid_ready_back", in_ready, 1);
        chk("skid_stall_hold", stall_cnt, 1);
        drive(1'b0, '0, '0);
        step();
        chk("skid_c_dropped", out_valid, 0);

        // 4: flush while in SKID with a new beat offered
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 8'h01);
        step();
        drive(1'b1, 16'h00BB, 8'h02);
        step();
        chk("flush_pre_ready", in_ready, 0);
        drive(1'b1, 16'h00CC, 8'h03);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_ctrl", out_ctrl, CR);
        chk("flush_data_kept", out_data, 16'h00AA);
        chk("flush_stall", stall_cnt, 3);
        out_ready = 1'b1;
        step();
        chk("flush_no_b", out_valid, 0);
        step();
        chk("flush_no_c", out_valid, 0);

        // 5: stall counter saturation (4-bit)
        out_ready = 1'b0;
        drive(1'b1, 16'h5555, 8'h55);
        step();
        drive(1'b0, '0, '0);
        repeat (11) step();
        chk("sat_14", stall_cnt, 14);
        step();
        chk("sat_15", stall_cnt, 15);
        repeat (8) step();
        chk("sat_stick", stall_cnt, 15);
        chk("sat_held_data", out_data, 16'h5555);
        out_ready = 1'b1;
        step();
        chk("sat_drain", out_valid, 0);
        chk("sat_after_drain", stall_cnt, 15);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("sat_reset_clear", stall_cnt, 0);

        // 6: random traffic against a queue scoreboard
        scnt = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            in_ctrl   = CW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            m_valid   = (q.size() > 0);
            m_ready   = (q.size() < 2);
            chk("rnd_valid", out_valid, m_valid);
            chk("rnd_ready", in_ready, m_ready);
            if (m_valid) chk("rnd_beat", {out_ctrl, out_data}, q[0]);
            else         chk("rnd_idle_ctrl", out_ctrl, CR);
            if (m_valid && !out_ready && scnt != 15) scnt++;
            if (m_valid && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && m_ready) q.push_back({in_ctrl, in_data});
            step();
            chk("rnd_stall", stall_cnt, scnt);
        end
        flush = 1'b0;
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
